inference_sequencer: RTL
========================

Name: inference_sequencer

Overview:
- Top-level controller for one MNIST inference frame.
- Sequences the 28-row x 7-bit image load into the 14x14 image buffer, then starts and resets the digit classifier.
- Supervises the classifier with a timeout, handles the test-digit bypass, and holds the BCD result and complete flag for the host handshake.
- Sits between the pin-level host interface and the image buffer, classifier and seg7 decoder.

Parameters:
- ROWS, 28, image rows per frame.
- ROW_W, 7, bits per row.
- TIMEOUT, 4096, maximum cycles spent in WAIT before ERROR.
- TMR_W, 12, timer width; must satisfy 2^TMR_W >= TIMEOUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- load_en  in  1  host frame enable; high = frame active, low = idle/abort/acknowledge.
- row_in  in  7  host image row; passed through to row_data.
- row_wr  out  1  image buffer write strobe (combinational).
- row_idx  out  5  buffer row address (registered).
- row_data  out  7  equals row_in.
- img_is_test  in  1  buffer reports the whole image value is <= 9.
- test_digit  in  4  low 4 image bits; valid when img_is_test = 1.
- cls_rst_n  out  1  classifier reset, active low (registered).
- cls_start  out  1  one-cycle classifier start pulse (registered).
- cls_valid  in  1  classifier result valid.
- cls_digit  in  4  classifier BCD result.
- result_bcd  out  4  latched digit, routed to BCD pins and seg7.
- result_valid  out  1  complete flag.
- error  out  1  timeout or illegal digit.
- busy  out  1  high in LOAD, START and WAIT.
- frame_count  out  8  completed frames; wraps modulo 256.

Behaviour:
- Reset values (rst_n low at a clk edge): state IDLE, row_idx 0, cls_rst_n 0, cls_start 0, result_bcd 0, result_valid 0, error 0, frame_count 0, timer 0.
- Reset mid-operation has the same effect. No partial result survives reset.
- States: IDLE, LOAD, START, WAIT, DONE, ERROR.
- row_wr = load_en & (state IDLE or LOAD). It is never asserted in any other state.
- IDLE:
  - load_en high: write row 0 this cycle, row_idx <= 1, go to LOAD.
  - cls_rst_n is 0 in IDLE.
- LOAD:
  - load_en high: write row row_idx. If row_idx = ROWS-1, go to START and set row_idx <= 0; otherwise row_idx increments.
  - load_en low: abort. Go to IDLE, row_idx <= 0, no start is issued.
- Load timing: the 28 rows occupy 28 consecutive load_en-high cycles (0..27). START is entered at cycle 28.
- START (one cycle):
  - cls_rst_n <= 1.
  - img_is_test = 1: result_bcd <= test_digit, go to DONE. cls_start is not pulsed.
  - img_is_test = 0: cls_start <= 1 for exactly one cycle, timer <= 0, go to WAIT.
- WAIT (priority from highest):
  1. load_en low: IDLE, cls_rst_n <= 0.
  2. cls_valid with cls_digit <= 9: result_bcd <= cls_digit, go to DONE.
  3. cls_valid with cls_digit > 9: ERROR; result_bcd unchanged.
  4. timer = TIMEOUT-1: ERROR.
  5. Otherwise timer increments.
  - cls_valid wins over timeout in the same cycle.
- DONE:
  - result_valid = 1, error = 0.
  - frame_count increments once on DONE entry (255 -> 0).
  - Stays in DONE until load_en is low, then IDLE with cls_rst_n <= 0. result_valid falls on that same edge.
  - result_bcd is retained through IDLE until the next DONE entry.
- ERROR:
  - error = 1, result_valid = 0, cls_rst_n = 0.
  - Exits to IDLE when load_en is low; error clears on exit.
- load_en held high after DONE/ERROR never re-arms a frame. The host must drop load_en for at least 1 cycle.
- All outputs except row_wr and row_data are registered.

Decomposition:
- Shared package nn_pkg holds:
  - state enum seq_state_t (IDLE, LOAD, START, WAIT, DONE, ERROR);
  - IMG_ROWS = 28, ROW_W = 7, BCD_MAX = 9.
- Natural sub-module: seq_watchdog, the WAIT timeout counter with clear/enable inputs and an expire output.

Test Plan:
- Normal frame: load_en high 28 cycles with rows, img_is_test = 0, cls_valid with digit 7 at 10 cycles after cls_start -> row_wr high 28 cycles with row_idx 0..27; one cls_start pulse at cycle 28; result_bcd = 7; result_valid = 1; frame_count = 1.
- Test bypass: img_is_test = 1, test_digit = 3 -> no cls_start pulse; DONE one cycle after START; result_bcd = 3, result_valid = 1.
- Abort: load_en drops after row 12 -> IDLE, row_idx = 0, no cls_start. A following full 28-row frame completes normally.
- Timeout: cls_valid never asserted, TIMEOUT = 16 -> error = 1 exactly 16 cycles after WAIT entry; result_valid = 0; cleared after load_en low.
- Boundaries:
  - cls_valid and timer expiry in the same cycle -> DONE.
  - cls_digit = 12 -> ERROR.
  - 256 frames -> frame_count wraps to 0.
- Reset mid-WAIT: rst_n low for 1 cycle -> all outputs at reset values on the next cycle; cls_rst_n = 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the MNIST inference frame sequencer.
package nn_pkg;

  localparam int IMG_ROWS = 28;
  localparam int ROW_W    = 7;
  localparam int BCD_MAX  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Classifier response timer: counts enabled cycles, expire flags the last allowed cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 4096,
  parameter int TMR_W   = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign expire = en && (count == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/inference_sequencer.sv
// Frame controller: loads 28 image rows, runs or bypasses the classifier, holds the result for the host.
module inference_sequencer
  import nn_pkg::*;
#(
  parameter int ROWS    = nn_pkg::IMG_ROWS,
  parameter int ROW_W   = nn_pkg::ROW_W,
  parameter int TIMEOUT = 4096,
  parameter int TMR_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [ROW_W-1:0] row_in,
  output logic             row_wr,
  output logic [4:0]       row_idx,
  output logic [ROW_W-1:0] row_data,
  input  logic             img_is_test,
  input  logic [3:0]       test_digit,
  output logic             cls_rst_n,
  output logic             cls_start,
  input  logic             cls_valid,
  input  logic [3:0]       cls_digit,
  output logic [3:0]       result_bcd,
  output logic             result_valid,
  output logic             error,
  output logic             busy,
  output logic [7:0]       frame_count
);

  seq_state_t state, state_nxt;
  logic       wd_expire;
  logic       digit_ok;

  assign digit_ok = cls_digit <= 4'(BCD_MAX);
  assign row_wr   = load_en && (state == ST_IDLE || state == ST_LOAD);
  assign row_data = row_in;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ST_WAIT),
    .en     (state == ST_WAIT),
    .expire (wd_expire)
  );

  // A classifier answer in the expiry cycle still counts as a result.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load_en) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (!load_en)                       state_nxt = ST_IDLE;
        else if (row_idx == 5'(ROWS - 1))   state_nxt = ST_START;
      end
      ST_START: state_nxt = img_is_test ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (!load_en)       state_nxt = ST_IDLE;
        else if (cls_valid) state_nxt = digit_ok ? ST_DONE : ST_ERROR;
        else if (wd_expire) state_nxt = ST_ERROR;
      end
      ST_DONE, ST_ERROR: if (!load_en) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      row_idx      <= '0;
      cls_rst_n    <= 1'b0;
      cls_start    <= 1'b0;
      result_bcd   <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_nxt;
      row_idx      <= (state_nxt == ST_LOAD) ? row_idx + 5'd1 : 5'd0;
      cls_rst_n    <= (state_nxt == ST_WAIT) || (state_nxt == ST_DONE);
      cls_start    <= (state == ST_START) && !img_is_test;
      result_valid <= (state_nxt == ST_DONE);
      error        <= (state_nxt == ST_ERROR);
      busy         <= (state_nxt == ST_LOAD) || (state_nxt == ST_START) ||
                      (state_nxt == ST_WAIT);
      if (state == ST_START && img_is_test)
        result_bcd <= test_digit;
      else if (state == ST_WAIT && load_en && cls_valid && digit_ok)
        result_bcd <= cls_digit;
      if (state_nxt == ST_DONE && state != ST_DONE)
        frame_count <= frame_count + 8'd1;
    end
  end

endmodule
